// File: rtl/riscv_core_rob_ctrl.sv
// Reorder-buffer control for the dual-issue core: in-order dual allocate, out-of-order fill, in-order dual retire.
// Optional squash support is compiled in with `define RISCV_ROB_FLUSH_EN.

module riscv_core_rob_entry (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       alloc,
  input  logic       alloc_wen,
  input  logic [4:0] alloc_rdst,
  input  logic       fill,
  input  logic       retire,
  output logic       valid,
  output logic       done,
  output logic       wen,
  output logic [4:0] rdst
);
  // Retire outranks fill so a completion racing its own retirement is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      done  <= 1'b0;
      wen   <= 1'b0;
      rdst  <= '0;
    end else if (flush || retire) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (alloc) begin
      valid <= 1'b1;
      done  <= 1'b0;
      wen   <= alloc_wen;
      rdst  <= alloc_rdst;
    end else if (fill && valid) begin
      done  <= 1'b1;
    end
  end
endmodule

module riscv_core_rob_ctrl #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rob_alloc_req0,
  input  logic       rob_alloc_req1,
  input  logic       rob_alloc_wen0,
  input  logic [4:0] rob_alloc_rdst0,
  input  logic       rob_alloc_wen1,
  input  logic [4:0] rob_alloc_rdst1,
  output logic       rob_alloc_rdy,
  output logic [4:0] rob_alloc_slot0,
  output logic [4:0] rob_alloc_slot1,
  input  logic       rob_fill_val0,
  input  logic [4:0] rob_fill_slot0,
  input  logic       rob_fill_val1,
  input  logic [4:0] rob_fill_slot1,
  output logic       rob_commit_val_1,
  output logic [4:0] rob_commit_slot_1,
  output logic       rob_commit_wen_1,
  output logic [4:0] rob_commit_rdst_1,
  output logic       rob_commit_val_2,
  output logic [4:0] rob_commit_slot_2,
  output logic       rob_commit_wen_2,
  output logic [4:0] rob_commit_rdst_2,
  input  logic       rob_flush,
  output logic [5:0] rob_count
);
  logic [PTR_W:0]            head, tail, count;
  logic [PTR_W-1:0]          h0, h1, t0, t1;
  logic [DEPTH-1:0]          valid, done, wen;
  logic [DEPTH-1:0][4:0]     rdst;
  logic                      do0, do1, cv1, cv2, flush;

`ifdef RISCV_ROB_FLUSH_EN
  assign flush = rob_flush;
`else
  logic unused_rob_flush;
  assign unused_rob_flush = rob_flush;
  assign flush = 1'b0;
`endif

  assign count = tail - head;
  assign h0    = head[PTR_W-1:0];
  assign h1    = h0 + 1'b1;
  assign t0    = tail[PTR_W-1:0];
  assign t1    = t0 + 1'b1;

  // Readiness uses registered occupancy only; same-cycle retirements free space next cycle.
  assign rob_alloc_rdy = (count <= (PTR_W+1)'(DEPTH - 2));
  assign do0 = rob_alloc_rdy & rob_alloc_req0;
  assign do1 = do0 & rob_alloc_req1;

  assign cv1 = valid[h0] & done[h0];
  assign cv2 = cv1 & valid[h1] & done[h1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam logic [PTR_W-1:0] IDX = PTR_W'(i);
    logic a0, a1;
    assign a0 = do0 && (t0 == IDX);
    assign a1 = do1 && (t1 == IDX);
    riscv_core_rob_entry u_ent (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .alloc     (a0 | a1),
      .alloc_wen (a0 ? rob_alloc_wen0  : rob_alloc_wen1),
      .alloc_rdst(a0 ? rob_alloc_rdst0 : rob_alloc_rdst1),
      .fill      ((rob_fill_val0 && rob_fill_slot0 == 5'(i)) ||
                  (rob_fill_val1 && rob_fill_slot1 == 5'(i))),
      .retire    ((cv1 && h0 == IDX) || (cv2 && h1 == IDX)),
      .valid     (valid[i]),
      .done      (done[i]),
      .wen       (wen[i]),
      .rdst      (rdst[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + (PTR_W+1)'(cv1) + (PTR_W+1)'(cv2);
      tail <= tail + (PTR_W+1)'(do0) + (PTR_W+1)'(do1);
    end
  end

  always_comb begin
    rob_alloc_slot0 = '0;
    rob_alloc_slot1 = '0;
    rob_alloc_slot0[PTR_W-1:0] = t0;
    rob_alloc_slot1[PTR_W-1:0] = t1;

    rob_commit_val_1  = cv1;
    rob_commit_slot_1 = '0;
    rob_commit_wen_1  = 1'b0;
    rob_commit_rdst_1 = '0;
    if (cv1) begin
      rob_commit_slot_1[PTR_W-1:0] = h0;
      rob_commit_wen_1  = wen[h0];
      rob_commit_rdst_1 = rdst[h0];
    end

    rob_commit_val_2  = cv2;
    rob_commit_slot_2 = '0;
    rob_commit_wen_2  = 1'b0;
    rob_commit_rdst_2 = '0;
    if (cv2) begin
      rob_commit_slot_2[PTR_W-1:0] = h1;
      rob_commit_wen_2  = wen[h1];
      rob_commit_rdst_2 = rdst[h1];
    end
  end

  assign rob_count = 6'(count);
endmodule

// File: tb/tb_riscv_core_rob_ctrl.sv
// Directed bench for riscv_core_rob_ctrl: alloc, fill, in-order retire, full/hold, wrap and flush.
module tb_riscv_core_rob_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, wen0, wen1, fv0, fv1, flush;
  logic [4:0] rdst0, rdst1, fs0, fs1;
  logic       rdy, cv1, cv2, cw1, cw2;
  logic [4:0] slot0, slot1, cs1, cs2, cr1, cr2;
  logic [5:0] count;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  riscv_core_rob_ctrl dut (
    .clk(clk), .reset(reset),
    .rob_alloc_req0(req0), .rob_alloc_req1(req1),
    .rob_alloc_wen0(wen0), .rob_alloc_rdst0(rdst0),
    .rob_alloc_wen1(wen1), .rob_alloc_rdst1(rdst1),
    .rob_alloc_rdy(rdy), .rob_alloc_slot0(slot0), .rob_alloc_slot1(slot1),
    .rob_fill_val0(fv0), .rob_fill_slot0(fs0),
    .rob_fill_val1(fv1), .rob_fill_slot1(fs1),
    .rob_commit_val_1(cv1), .rob_commit_slot_1(cs1),
    .rob_commit_wen_1(cw1), .rob_commit_rdst_1(cr1),
    .rob_commit_val_2(cv2), .rob_commit_slot_2(cs2),
    .rob_commit_wen_2(cw2), .rob_commit_rdst_2(cr2),
    .rob_flush(flush), .rob_count(count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req0 = 0; req1 = 0; fv0 = 0; fv1 = 0; flush = 0;
  endtask

  task automatic test_reset;
    reset = 1; idle(); wen0 = 0; wen1 = 0; rdst0 = 0; rdst1 = 0; fs0 = 0; fs1 = 0;
    repeat (2) tick();
    reset = 0;
    tests++; if (rdy !== 1'b1)   begin fails++; $display("FAIL reset_rdy got %0d exp 1", rdy); end
    tests++; if (slot0 !== 5'd0) begin fails++; $display("FAIL reset_slot0 got %0d exp 0", slot0); end
    tests++; if (slot1 !== 5'd1) begin fails++; $display("FAIL reset_slot1 got %0d exp 1", slot1); end
    tests++; if ({cv1, cv2, cs1, cs2, cw1, cw2, cr1, cr2} !== '0)
      begin fails++; $display("FAIL reset_commit got %0d/%0d exp 0/0", cv1, cv2); end
    tests++; if (count !== 6'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
  endtask

  task automatic test_dual_alloc;
    req0 = 1; req1 = 1; wen0 = 1; wen1 = 1; rdst0 = 3; rdst1 = 4;
    tests++; if (slot0 !== 5'd0 || slot1 !== 5'd1)
      begin fails++; $display("FAIL alloc_slots got %0d/%0d exp 0/1", slot0, slot1); end
    tick(); idle();
    tests++; if (count !== 6'd2) begin fails++; $display("FAIL alloc_count got %0d exp 2", count); end
    tests++; if (slot0 !== 5'd2) begin fails++; $display("FAIL alloc_tail got %0d exp 2", slot0); end
  endtask

  task automatic test_fill_order;
    fv1 = 1; fs1 = 1;
    tick(); idle();
    tests++; if (cv1 !== 0 || cv2 !== 0) begin fails++; $display("FAIL fill_n1 got %0d/%0d exp 0/0", cv1, cv2); end
    tick();
    tests++; if (cv1 !== 0 || cv2 !== 0) begin fails++; $display("FAIL fill_n2 got %0d/%0d exp 0/0", cv1, cv2); end
    fv0 = 1; fs0 = 0;
    tick(); idle();
    tests++; if (cv1 !== 1 || cs1 !== 5'd0 || cw1 !== 1 || cr1 !== 5'd3)
      begin fails++; $display("FAIL commit1 got v%0d s%0d w%0d r%0d exp v1 s0 w1 r3", cv1, cs1, cw1, cr1); end
    tests++; if (cv2 !== 1 || cs2 !== 5'd1 || cw2 !== 1 || cr2 !== 5'd4)
      begin fails++; $display("FAIL commit2 got v%0d s%0d w%0d r%0d exp v1 s1 w1 r4", cv2, cs2, cw2, cr2); end
    tick();
    tests++; if (count !== 6'd0 || cv1 !== 0)
      begin fails++; $display("FAIL drain_count got %0d v%0d exp 0 v0", count, cv1); end
  endtask

  // head=tail=2 on entry; fills entries 2..15 and 0
  task automatic test_full_hold;
    for (int k = 0; k < 7; k++) begin
      tests++; if (rdy !== 1) begin fails++; $display("FAIL full_rdy%0d got %0d exp 1", k, rdy); end
      req0 = 1; req1 = 1; wen0 = 1; wen1 = 1; rdst0 = 5'(k); rdst1 = 5'(k + 16);
      tick();
    end
    idle();
    tests++; if (count !== 6'd14 || rdy !== 1)
      begin fails++; $display("FAIL count14 got %0d rdy%0d exp 14 rdy1", count, rdy); end
    req0 = 1; wen0 = 0; rdst0 = 9;
    tick(); idle();
    tests++; if (count !== 6'd15 || rdy !== 0 || slot0 !== 5'd1)
      begin fails++; $display("FAIL count15 got %0d rdy%0d s%0d exp 15 rdy0 s1", count, rdy, slot0); end
    req0 = 1; wen0 = 1;
    repeat (3) tick();
    idle();
    tests++; if (count !== 6'd15 || slot0 !== 5'd1)
      begin fails++; $display("FAIL hold got %0d s%0d exp 15 s1", count, slot0); end
  endtask

  task automatic test_head_block;
    fv1 = 1; fs1 = 3;
    tick(); idle();
    tests++; if (cv1 !== 0 || cv2 !== 0) begin fails++; $display("FAIL block got %0d/%0d exp 0/0", cv1, cv2); end
    fv0 = 1; fs0 = 2;
    tick(); idle();
    tests++; if (cv1 !== 1 || cs1 !== 5'd2 || cr1 !== 5'd0 || cv2 !== 1 || cs2 !== 5'd3 || cr2 !== 5'd16)
      begin fails++; $display("FAIL unblock got s%0d r%0d s%0d r%0d exp s2 r0 s3 r16", cs1, cr1, cs2, cr2); end
    tick();
    tests++; if (count !== 6'd13 || rdy !== 1)
      begin fails++; $display("FAIL after_unblock got %0d rdy%0d exp 13 rdy1", count, rdy); end
  endtask

  // Fill the remaining slots 4..15,0 two at a time and check retirement order as they drain
  task automatic test_drain_order;
    int nf = 0;
    int exp_s = 4;
    int n = 0;
    int bad = 0;
    while ((count != 0 || nf < 13) && n < 40) begin
      if (cv1) begin
        if (cs1 !== 5'(exp_s)) bad++;
        exp_s = (exp_s + 1) % 16;
      end
      if (cv2) begin
        if (cs2 !== 5'(exp_s)) bad++;
        exp_s = (exp_s + 1) % 16;
      end
      fv0 = 0; fv1 = 0;
      if (nf < 13) begin fv0 = 1; fs0 = 5'((4 + nf) % 16); nf++; end
      if (nf < 13) begin fv1 = 1; fs1 = 5'((4 + nf) % 16); nf++; end
      tick(); n++;
    end
    idle();
    tests++; if (bad != 0 || exp_s != 1)
      begin fails++; $display("FAIL drain_order got %0d bad next%0d exp 0 bad next1", bad, exp_s); end
    tests++; if (count !== 6'd0) begin fails++; $display("FAIL drain_empty got %0d exp 0", count); end
  endtask

  task automatic test_wrap;
    int n = 0;
    for (int k = 0; k < 7; k++) begin
      req0 = 1; req1 = 1; wen0 = 1; wen1 = 1; rdst0 = 1; rdst1 = 2;
      tick(); idle();
      fv0 = 1; fs0 = 5'(1 + 2 * k); fv1 = 1; fs1 = 5'(2 + 2 * k);
      tick(); idle();
    end
    while (count != 0 && n < 20) begin tick(); n++; end
    tests++; if (count !== 6'd0 || slot0 !== 5'd15 || slot1 !== 5'd0)
      begin fails++; $display("FAIL wrap_slots got c%0d %0d/%0d exp c0 15/0", count, slot0, slot1); end
    req0 = 1; req1 = 1; wen0 = 1; wen1 = 0; rdst0 = 7; rdst1 = 8;
    tick(); idle();
    fv0 = 1; fs0 = 0; fv1 = 1; fs1 = 15;
    tick(); idle();
    tests++; if (cv1 !== 1 || cs1 !== 5'd15 || cw1 !== 1 || cr1 !== 5'd7 || cv2 !== 1 || cs2 !== 5'd0 || cw2 !== 0 || cr2 !== 5'd8)
      begin fails++; $display("FAIL wrap_commit got s%0d r%0d s%0d w%0d r%0d exp s15 r7 s0 w0 r8", cs1, cr1, cs2, cw2, cr2); end
    tick();
    tests++; if (count !== 6'd0 || slot0 !== 5'd1)
      begin fails++; $display("FAIL wrap_empty got %0d s%0d exp 0 s1", count, slot0); end
  endtask

  // head=tail=1; five entries occupy slots 1..5
  task automatic test_flush;
    req0 = 1; req1 = 1; wen0 = 1; wen1 = 1; rdst0 = 10; rdst1 = 11; tick();
    tick();
    req1 = 0; tick(); idle();
    tests++; if (count !== 6'd5) begin fails++; $display("FAIL pre_flush got %0d exp 5", count); end
    flush = 1; fv0 = 1; fs0 = 1;
    tick(); idle();
`ifdef RISCV_ROB_FLUSH_EN
    tests++; if (count !== 6'd0 || cv1 !== 0 || cv2 !== 0 || rdy !== 1 || slot0 !== 5'd0)
      begin fails++; $display("FAIL flush got c%0d v%0d rdy%0d s%0d exp c0 v0 rdy1 s0", count, cv1, rdy, slot0); end
`else
    tests++; if (count !== 6'd5 || cv1 !== 1 || cs1 !== 5'd1 || cr1 !== 5'd10 || cv2 !== 0)
      begin fails++; $display("FAIL noflush got c%0d v%0d s%0d r%0d exp c5 v1 s1 r10", count, cv1, cs1, cr1); end
`endif
  endtask

  initial begin
    test_reset();
    test_dual_alloc();
    test_fill_order();
    test_full_hold();
    test_head_block();
    test_drain_order();
    test_wrap();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/riscv_core_rob_ctrl.md
Name: riscv_core_rob_ctrl

Overview:
- Reorder-buffer control for the dual-issue IO2I core.
- Allocates up to two in-order ROB slots per cycle at issue and records completions from pipelines A/B.
- Retires up to two oldest completed entries per cycle in program order.
- Commit outputs (rob_commit_val_1/2, rob_commit_slot_1/2) drive the scoreboard's pending-release inputs and the architectural register write-back. Control/tag only; result data lives in a separate array indexed by slot.

Parameters:
DEPTH, 16, number of ROB entries; power of two, 4..32
PTR_W, 4, log2(DEPTH); slot ports are fixed 5 bits wide, upper bits zero

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
rob_alloc_req0  input  1  allocate a slot for ir0 (older)
rob_alloc_req1  input  1  allocate a slot for ir1; legal only with rob_alloc_req0
rob_alloc_wen0  input  1  ir0 writes a register
rob_alloc_rdst0  input  5  ir0 destination register
rob_alloc_wen1  input  1  ir1 writes a register
rob_alloc_rdst1  input  5  ir1 destination register
rob_alloc_rdy  output  1  at least two free entries
rob_alloc_slot0  output  5  slot granted to ir0 (= tail)
rob_alloc_slot1  output  5  slot granted to ir1 (= tail+1 mod DEPTH)
rob_fill_val0  input  1  completion from pipeline A writeback
rob_fill_slot0  input  5  slot completed by pipeline A
rob_fill_val1  input  1  completion from pipeline B writeback
rob_fill_slot1  input  5  slot completed by pipeline B
rob_commit_val_1  output  1  oldest entry retires this cycle
rob_commit_slot_1  output  5  slot of oldest retiring entry
rob_commit_wen_1  output  1  first commit writes the register file
rob_commit_rdst_1  output  5  first commit destination
rob_commit_val_2  output  1  second-oldest entry retires this cycle
rob_commit_slot_2  output  5  slot of second retiring entry
rob_commit_wen_2  output  1  second commit writes the register file
rob_commit_rdst_2  output  5  second commit destination
rob_flush  input  1  squash all entries (macro-gated, see Optional Feature)
rob_count  output  6  occupied entries

Behaviour:
- State per entry: valid, done, wen, rdst[4:0].
- Pointers: head and tail, PTR_W+1 bits each; the extra MSB is the wrap bit. count = tail - head. Empty when pointers are equal; full when low bits are equal and wrap bits differ.
- Reset: valid and done cleared, head = tail = 0. rob_alloc_rdy = 1, rob_alloc_slot0 = 0, rob_alloc_slot1 = 1, all commit outputs 0, rob_count = 0.

Allocation:
- rob_alloc_rdy = (DEPTH - count >= 2), computed from registered count only.
- Slots freed by a same-cycle commit are not visible until the next cycle.
- Allocation occurs when rob_alloc_rdy is high and a request is asserted. req0 writes entry tail; req1 writes entry tail+1. Each written entry gets valid=1, done=0, and its wen/rdst.
- tail advances by req0 + req1 at the clock edge.
- Requests while rob_alloc_rdy = 0 are ignored; issue logic must hold the instruction.
- req1 without req0 is illegal; the block treats it as no request.

Fill:
- A fill sets done=1 on its slot at the clock edge, but only if that entry is valid.
- A fill to an invalid slot is ignored.
- Both fills to the same slot in one cycle: done=1, no error.

Commit (combinational from registered state; no same-cycle fill-to-commit path):
- commit_val_1 = valid[head] & done[head].
- commit_val_2 = commit_val_1 & valid[head+1] & done[head+1].
- A completed head+1 never retires ahead of an incomplete head.
- Slot, wen and rdst outputs reflect head and head+1. They are driven 0 when the corresponding val is 0.
- At the clock edge, retired entries are cleared (valid=0, done=0) and head advances by commit_val_1 + commit_val_2.
- Minimum latency: fill at cycle N, commit visible at N+1.

Simultaneous events:
- Alloc and commit in one cycle: count_next = count + allocs - commits.
- An entry is never allocated and committed in the same cycle.
- A fill targeting an entry being retired has no effect.
- Wrap-around: slot indices are taken mod DEPTH. Slot1 wraps to 0 when tail low bits = DEPTH-1.

Optional Feature:
- Macro: RISCV_ROB_FLUSH_EN.
- Defined: rob_flush high at an edge clears all valid/done bits and sets head = tail = 0. Flush has priority over same-cycle alloc, fill and commit. Commit outputs are 0 in the cycle after the flush. rob_alloc_rdy = 1 next cycle.
- Undefined: the rob_flush port exists but is ignored; no flush logic is synthesized.

Test Plan:
- Reset, then dual alloc (req0=req1=1, rdst 3/4) -> slots 0/1 granted; rob_count=2 next cycle.
- Fill slot1 at cycle N, fill slot0 at cycle N+2 -> no commit through N+2; at N+3 commit_val_1=1 slot 0 rdst 3, commit_val_2=1 slot 1 rdst 4; rob_count=0 at N+4.
- Alloc 14 entries (7 dual allocs) -> rob_alloc_rdy stays 1 at count 14. Single alloc to count 15 -> rob_alloc_rdy=0. req0 held high for 3 cycles -> no allocation, tail unchanged.
- Fill only head+1 -> commit_val_1=0, commit_val_2=0. Then fill head -> both commit the next cycle.
- Wrap case: tail=15, dual alloc -> slot0=15, slot1=0. Complete both -> commits in order 15 then 0.
- With RISCV_ROB_FLUSH_EN: 5 valid entries, rob_flush=1 concurrent with a fill -> next cycle rob_count=0, commit vals 0. Without the macro, the same stimulus -> rob_count=5, unchanged.
